uart_tx_arbiter: RTL and testbench

- Shares one UART transmitter between N_REQ byte requesters using round-robin arbitration.
- Captures the winning requester's byte and pulses a one-cycle start to the transmitter.
- Tracks the transmitter's busy signal through the full frame, then re-arbitrates.
- Sits between protocol producers (command responder, status reporter, loopback path) and the single uart_tx instance driving the board TX pin.

---
 rtl/uart_tx_arbiter.sv | 156 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that shares one UART transmitter
// between N_REQ byte requesters. A grant captures the winner's byte and
// raises tx_start for one cycle. The arbiter then follows tx_busy through
// the whole frame before it arbitrates again.
// Optional feature (macro ARB_BURST_EN): a requester keeps the transmitter
// until it sends a byte with req_last=1, or until it drops req.
module uart_tx_arbiter #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8,
    parameter int ID_W   = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    input  logic [N_REQ-1:0]          req_last,
    output logic [N_REQ-1:0]          ack,
    output logic [DATA_W-1:0]         tx_data,
    output logic                      tx_start,
    input  logic                      tx_busy,
    output logic [ID_W-1:0]           grant_id,
    output logic                      active
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t              state, state_next;
    logic [ID_W-1:0]     ptr, ptr_next;
    logic [N_REQ-1:0]    ack_next;
    logic [DATA_W-1:0]   tx_data_next;
    logic                tx_start_next;
    logic [ID_W-1:0]     grant_id_next;
    logic                active_next;

    logic [ID_W-1:0]     scan_idx;
    logic [ID_W-1:0]     rr_winner;
    logic [ID_W-1:0]     winner;
    logic                hold;

    // Index successor with an explicit wrap, so that N_REQ need not be a power of 2.
    function automatic logic [ID_W-1:0] next_idx(input logic [ID_W-1:0] i);
        return (i == ID_W'(N_REQ - 1)) ? '0 : i + 1'b1;
    endfunction

`ifdef ARB_BURST_EN
    // msg_open is set while the granted requester's message is still unfinished.
    logic msg_open, msg_open_next;
    assign hold = msg_open && req[grant_id];
`else
    logic unused_last;
    assign unused_last = ^req_last;
    assign hold        = 1'b0;
`endif

    // Round-robin scan: the first pending requester at or after ptr.
    always_comb begin
        // NOTE: every variable gets a value before any branch; otherwise always_comb infers a latch.
        rr_winner = ptr;
        scan_idx  = ptr;
        for (int k = 0; k < N_REQ; k++) begin
            if (req[scan_idx] && (rr_winner == ptr) && !req[ptr]) begin
                rr_winner = scan_idx;
            end
            scan_idx = next_idx(scan_idx);
        end
    end

    // An open burst keeps the previous requester; otherwise round-robin decides.
    assign winner = hold ? grant_id : rr_winner;

    // Next-state and registered-output logic of the grant FSM.
    always_comb begin
        state_next    = state;
        ptr_next      = ptr;
        ack_next      = '0;
        tx_start_next = 1'b0;
        tx_data_next  = tx_data;
        grant_id_next = grant_id;
`ifdef ARB_BURST_EN
        msg_open_next = msg_open;
`endif
        case (state)
            IDLE: begin
`ifdef ARB_BURST_EN
                if (msg_open && !req[grant_id]) begin
                    msg_open_next = 1'b0;
                end
`endif
                if (!tx_busy && (|req)) begin
                    tx_data_next     = req_data[int'(winner)*DATA_W +: DATA_W];
                    tx_start_next    = 1'b1;
                    ack_next[winner] = 1'b1;
                    grant_id_next    = winner;
                    state_next       = START;
`ifdef ARB_BURST_EN
                    msg_open_next    = !req_last[winner];
`endif
                end
            end
            START: begin
                state_next = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_next = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    state_next = IDLE;
                    // ptr always moves past the last grant. In burst mode an open
                    // message overrides ptr through hold. Dropping req releases it.
                    ptr_next   = next_idx(grant_id);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        active_next = (state_next != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            ack      <= '0;
            tx_data  <= '0;
            tx_start <= 1'b0;
            grant_id <= '0;
            active   <= 1'b0;
`ifdef ARB_BURST_EN
            msg_open <= 1'b0;
`endif
        end else begin
            state    <= state_next;
            ptr      <= ptr_next;
            ack      <= ack_next;
            tx_data  <= tx_data_next;
            tx_start <= tx_start_next;
            grant_id <= grant_id_next;
            active   <= active_next;
`ifdef ARB_BURST_EN
            msg_open <= msg_open_next;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench for uart_tx_arbiter.
// Requesters are byte queues and the transmitter is a busy-for-N-cycles model.
// The arbitration reference decides grant order from the rotation rules.
// A second instance with N_REQ=3 exercises the non-power-of-2 wrap.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      req = '0;
    logic [N*DW-1:0]   req_data = '0;
    logic [N-1:0]      req_last = '0;
    logic [N-1:0]      ack;
    logic [DW-1:0]     tx_data;
    logic              tx_start;
    logic              tx_busy = 1'b0;
    logic [IW-1:0]     grant_id;
    logic              active;

    logic [2:0]        req3 = '0;
    logic [23:0]       req_data3;
    logic [2:0]        req_last3;
    logic [2:0]        ack3;
    logic [7:0]        tx_data3;
    logic              tx_start3;
    logic              busy3 = 1'b0;
    logic [1:0]        grant_id3;
    logic              active3;

    assign req_data3 = 24'hC2C1C0;
    assign req_last3 = 3'b111;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.N_REQ(N), .DATA_W(DW), .ID_W(IW)) u_dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_last(req_last),
        .ack(ack), .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .grant_id(grant_id), .active(active)
    );

    uart_tx_arbiter #(.N_REQ(3), .DATA_W(8), .ID_W(2)) u_dut3 (
        .clk(clk), .rst(rst), .req(req3), .req_data(req_data3), .req_last(req_last3),
        .ack(ack3), .tx_data(tx_data3), .tx_start(tx_start3), .tx_busy(busy3),
        .grant_id(grant_id3), .active(active3)
    );

    typedef struct { int id; logic [7:0] data; } exp_t;
    typedef struct { logic [7:0] data; logic last; } item_t;

    int     n_checks = 0;
    int     n_pass   = 0;

    item_t  rq [N][$];
    exp_t   exp_q[$];
    exp_t   exp3[$];

    // Reference arbitration state.
    int     m_ptr = 0, m_gid = 0, m_g = 0, edge_no = 0;
    bit     m_open = 0, m_free = 1, m_rise = 0;

    // Environment state.
    bit     rst_drive = 1, ext_busy = 0, xmit_pending = 0, x3_pending = 0;
    int     busy_left = 0, frame_min = 2, frame_max = 8, n3 = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic int scan_from(input int start, input logic [N-1:0] r);
        for (int k = 0; k < N; k++) begin
            if (r[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    function automatic bit all_empty();
        for (int i = 0; i < N; i++) if (rq[i].size() != 0) return 0;
        return 1;
    endfunction

    // One clock: drive requesters/transmitter for the coming edge, then predict that edge.
    task automatic step();
        int    w;
        item_t it;
        @(negedge clk);
        if (xmit_pending) begin
            busy_left    = $urandom_range(frame_max, frame_min);
            xmit_pending = 0;
        end
        if (rst_drive) begin
            busy_left    = 0;
            xmit_pending = 0;
        end
        tx_busy = (busy_left > 0) || ext_busy;
        if (busy_left > 0) busy_left--;
        for (int i = 0; i < N; i++) begin
            if (rq[i].size() > 0) begin
                req[i]            = 1'b1;
                req_data[i*DW +: DW] = rq[i][0].data;
                req_last[i]       = rq[i][0].last;
            end else begin
                req[i]      = 1'b0;
                req_last[i] = 1'b0;
            end
        end
        rst = rst_drive;
        edge_no++;
        if (rst_drive) begin
            m_ptr = 0; m_gid = 0; m_open = 0; m_free = 1; m_rise = 0;
            exp_q.delete();
        end else if (m_free) begin
`ifdef ARB_BURST_EN
            if (m_open && !req[m_gid]) begin
                m_open = 0;
                m_ptr  = (m_gid + 1) % N;
            end
`endif
            if (!tx_busy && req != '0) begin
                w  = m_open ? m_gid : scan_from(m_ptr, req);
                it = rq[w].pop_front();
                exp_q.push_back('{w, it.data});
`ifdef ARB_BURST_EN
                m_open = !it.last;
                if (it.last) m_ptr = (w + 1) % N;
`else
                m_ptr = (w + 1) % N;
`endif
                m_gid  = w;
                m_free = 0;
                m_g    = edge_no;
                m_rise = 0;
            end
        end else if (edge_no >= m_g + 2) begin
            if (!m_rise && tx_busy) m_rise = 1;
            else if (m_rise && !tx_busy) m_free = 1;
        end
    endtask

    task automatic enqueue(input int i, input logic [7:0] d, input logic last);
        rq[i].push_back('{d, last});
    endtask

    task automatic drain();
        int guard = 0;
        ext_busy = 0;
        while ((!all_empty() || !m_free || exp_q.size() != 0) && guard < 3000) begin
            step();
            guard++;
        end
        check("drain_done", guard < 3000, 1);
    endtask

    task automatic wait_frame_running();
        int guard = 0;
        while (!(!m_free && m_rise) && guard < 200) begin
            step();
            guard++;
        end
        check("frame_running", guard < 200, 1);
    endtask

    // Scoreboard monitor for the main instance.
    always begin : mon
        exp_t             e;
        logic [N-1:0]     ea;
        @(posedge clk);
        #1;
        if (rst) begin
            check("reset_outputs", {ack, tx_data, tx_start, grant_id, active}, '0);
        end else if (tx_start) begin
            xmit_pending = 1;
            if (exp_q.size() == 0) begin
                check("unexpected_tx_start", tx_start, 0);
            end else begin
                e = exp_q.pop_front();
                ea = '0;
                ea[e.id] = 1'b1;
                check("grant_id", grant_id, e.id);
                check("ack_onehot", ack, ea);
                check("tx_data", tx_data, e.data);
                check("active_on_start", active, 1);
            end
        end else begin
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("missing_tx_start", tx_start, 1);
            end
            check("ack_idle", ack, 0);
        end
    end

    // Scoreboard monitor for the N_REQ=3 instance.
    always begin : mon3
        exp_t e;
        @(posedge clk);
        #1;
        if (tx_start3) begin
            x3_pending = 1;
            n3++;
            if (exp3.size() == 0) begin
                check("n3_unexpected_start", tx_start3, 0);
            end else begin
                e = exp3.pop_front();
                check("n3_grant_id", grant_id3, e.id);
                check("n3_tx_data", tx_data3, e.data);
                check("n3_ack", ack3, 3'b001 << e.id);
            end
        end
    end

    task automatic run_n3();
        int guard = 0;
        int b3_left = 0;
        exp3.push_back('{1, 8'hC1});
        exp3.push_back('{2, 8'hC2});
        exp3.push_back('{0, 8'hC0});
        exp3.push_back('{2, 8'hC2});
        exp3.push_back('{0, 8'hC0});
        while (n3 < 5 && guard < 500) begin
            @(negedge clk);
            guard++;
            if (x3_pending) begin b3_left = 4; x3_pending = 0; end
            busy3 = b3_left > 0;
            if (b3_left > 0) b3_left--;
            req3 = (n3 == 0) ? 3'b010 : 3'b101;
        end
        req3 = '0;
        repeat (12) begin
            @(negedge clk);
            if (x3_pending) begin b3_left = 4; x3_pending = 0; end
            busy3 = b3_left > 0;
            if (b3_left > 0) b3_left--;
        end
        check("n3_grant_count", n3, 5);
        check("n3_queue_empty", exp3.size(), 0);
    endtask

    initial begin
        int i;
        repeat (2) step();
        rst_drive = 0;

        // Round-robin with all four pending and 20-cycle frames: 0,1,2,3,0.
        frame_min = 20; frame_max = 20;
        enqueue(0, 8'h10, 1); enqueue(1, 8'h11, 1);
        enqueue(2, 8'h12, 1); enqueue(3, 8'h13, 1);
        enqueue(0, 8'h14, 1);
        drain();

        // Reset while the frame is in progress, then a fresh grant of 0x41.
        frame_min = 10; frame_max = 10;
        enqueue(3, 8'h55, 1);
        wait_frame_running();
        repeat (2) step();
        rst_drive = 1; step(); rst_drive = 0;
        enqueue(0, 8'h41, 1);
        drain();

        // Busy gating: no start while tx_busy is held externally.
        ext_busy = 1;
        enqueue(2, 8'hA2, 1);
        repeat (10) step();
        drain();

        // Withdrawal during a running frame.
        enqueue(0, 8'h30, 1);
        wait_frame_running();
        enqueue(1, 8'h31, 1);
        repeat (2) step();
        rq[1].delete();
        drain();

        // Message of three bytes from requester 0 competing with requester 1.
        frame_min = 3; frame_max = 5;
        enqueue(0, 8'hB0, 0); enqueue(0, 8'hB1, 0); enqueue(0, 8'hB2, 1);
        enqueue(1, 8'hC0, 1); enqueue(1, 8'hC1, 1);
        drain();

        // Randomized traffic with withdrawals, busy stretching and occasional reset.
        frame_min = 2; frame_max = 8;
        repeat (3000) begin
            if ($urandom_range(3, 0) == 0) begin
                i = $urandom_range(N - 1, 0);
                if (rq[i].size() < 4) enqueue(i, 8'($urandom), $urandom_range(2, 0) == 0);
            end
            if ($urandom_range(59, 0) == 0) begin
                i = $urandom_range(N - 1, 0);
                if (rq[i].size() == 1) rq[i].delete();
            end
            if ($urandom_range(49, 0) == 0) ext_busy = !ext_busy;
            rst_drive = ($urandom_range(799, 0) == 0);
            step();
        end
        rst_drive = 0;
        drain();
        repeat (3) step();

        run_n3();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
